jimmy_core: RTL and testbench

- 8-bit multi-cycle Harvard CPU core: fetches instructions from a synchronous program memory, reads operands from a synchronous read-only data memory, and exchanges values through fixed I/O ports.
- Several instances share dual-port program and data memories in a multicore system. Each core gets its own work range through in_port_0 (start) and in_port_3 (end), and reports completion through out_port_2 and out_strobe[2].

---
 rtl/jimmy_core.sv | 203 ++++++++++++++++++++
 tb/tb_jimmy_core.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jimmy_core.sv
`default_nettype none
// jimmy_core: 8-bit multi-cycle Harvard CPU, 4 registers, Z/C flags, fixed I/O ports.
// Rev 1.0 -- fetch / immediate / execute / memory-wait sequencer; never writes memory.
module jimmy_core (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] code_data_bus,
  output logic [7:0] code_addr_bus,
  input  logic [7:0] mem_data_bus,
  output logic [7:0] mem_addr_bus,
  input  logic [7:0] in_port_0,
  input  logic [7:0] in_port_3,
  output logic [7:0] out_port_2,
  output logic [3:0] out_strobe
);

  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_MOV  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_LD   = 4'h5;
  localparam logic [3:0] OP_IN   = 4'h6;
  localparam logic [3:0] OP_OUT  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_JZ   = 4'h9;
  localparam logic [3:0] OP_JNZ  = 4'hA;
  localparam logic [3:0] OP_JC   = 4'hB;
  localparam logic [3:0] OP_INC  = 4'hC;
  localparam logic [3:0] OP_CMP  = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hE;

  typedef enum logic [2:0] {
    S_F1 = 3'd0,
    S_F2 = 3'd1,
    S_I1 = 3'd2,
    S_I2 = 3'd3,
    S_EX = 3'd4,
    S_M1 = 3'd5,
    S_M2 = 3'd6,
    S_H  = 3'd7
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] imm_q, imm_d;
  logic [7:0] rf_q [4];
  logic [7:0] rf_d [4];
  logic       z_q, z_d;
  logic       c_q, c_d;
  logic [7:0] code_addr_q, code_addr_d;
  logic [7:0] mem_addr_q, mem_addr_d;
  logic [7:0] port2_q, port2_d;
  logic [3:0] strobe_q, strobe_d;

  logic [3:0] op;
  logic [1:0] rd_sel;
  logic [1:0] rs_sel;
  logic [7:0] rd_val;
  logic [7:0] rs_val;
  logic [8:0] sum;
  logic [7:0] diff;
  logic [7:0] incv;

  assign op     = ir_q[7:4];
  assign rd_sel = ir_q[3:2];
  assign rs_sel = ir_q[1:0];
  assign rd_val = rf_q[rd_sel];
  assign rs_val = rf_q[rs_sel];
  assign sum    = {1'b0, rd_val} + {1'b0, rs_val};
  assign diff   = rd_val - rs_val;
  assign incv   = rd_val + 8'd1;

  function automatic logic is_two_byte(input logic [3:0] opc);
    return (opc == OP_LDI) || (opc == OP_JMP) || (opc == OP_JZ) ||
           (opc == OP_JNZ) || (opc == OP_JC);
  endfunction

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    imm_d       = imm_q;
    rf_d        = rf_q;
    z_d         = z_q;
    c_d         = c_q;
    code_addr_d = code_addr_q;
    mem_addr_d  = mem_addr_q;
    port2_d     = port2_q;
    strobe_d    = 4'b0000;

    case (state_q)
      S_F1: begin
        code_addr_d = pc_q;
        state_d     = S_F2;
      end
      S_F2: begin
        ir_d    = code_data_bus;
        pc_d    = pc_q + 8'd1;
        state_d = is_two_byte(code_data_bus[7:4]) ? S_I1 : S_EX;
      end
      S_I1: begin
        code_addr_d = pc_q;
        state_d     = S_I2;
      end
      S_I2: begin
        imm_d   = code_data_bus;
        pc_d    = pc_q + 8'd1;
        state_d = S_EX;
      end
      S_EX: begin
        state_d = S_F1;
        case (op)
          OP_LDI: rf_d[rd_sel] = imm_q;
          OP_MOV: rf_d[rd_sel] = rs_val;
          OP_ADD: begin
            rf_d[rd_sel] = sum[7:0];
            c_d          = sum[8];
            z_d          = (sum[7:0] == 8'd0);
          end
          OP_SUB: begin
            rf_d[rd_sel] = diff;
            c_d          = (rs_val > rd_val);
            z_d          = (diff == 8'd0);
          end
          OP_LD: begin
            mem_addr_d = rs_val;
            state_d    = S_M1;
          end
          OP_IN: begin
            case (rs_sel)
              2'd0:    rf_d[rd_sel] = in_port_0;
              2'd3:    rf_d[rd_sel] = in_port_3;
              default: rf_d[rd_sel] = 8'd0;
            endcase
          end
          OP_OUT: begin
            strobe_d[rd_sel] = 1'b1;
            if (rd_sel == 2'd2) port2_d = rs_val;
          end
          OP_JMP: pc_d = imm_q;
          OP_JZ:  if (z_q)  pc_d = imm_q;
          OP_JNZ: if (!z_q) pc_d = imm_q;
          OP_JC:  if (c_q)  pc_d = imm_q;
          OP_INC: begin
            rf_d[rd_sel] = incv;
            z_d          = (incv == 8'd0);
            c_d          = (incv == 8'd0);
          end
          OP_CMP: begin
            c_d = (rs_val > rd_val);
            z_d = (diff == 8'd0);
          end
          OP_HALT: state_d = S_H;
          default: ;
        endcase
      end
      // Data arrives one cycle after the address registered in EX.
      S_M1: state_d = S_M2;
      S_M2: begin
        rf_d[rd_sel] = mem_data_bus;
        state_d      = S_F1;
      end
      S_H:     state_d = S_H;
      default: state_d = S_F1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_F1;
      pc_q        <= 8'd0;
      ir_q        <= 8'd0;
      imm_q       <= 8'd0;
      for (int i = 0; i < 4; i++) rf_q[i] <= 8'd0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      code_addr_q <= 8'd0;
      mem_addr_q  <= 8'd0;
      port2_q     <= 8'd0;
      strobe_q    <= 4'b0000;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      imm_q       <= imm_d;
      rf_q        <= rf_d;
      z_q         <= z_d;
      c_q         <= c_d;
      code_addr_q <= code_addr_d;
      mem_addr_q  <= mem_addr_d;
      port2_q     <= port2_d;
      strobe_q    <= strobe_d;
    end
  end

  assign code_addr_bus = code_addr_q;
  assign mem_addr_bus  = mem_addr_q;
  assign out_port_2    = port2_q;
  assign out_strobe    = strobe_q;

endmodule
`default_nettype wire

// File: tb/tb_jimmy_core.sv
`default_nettype none
// tb_jimmy_core: two cores on shared program/data memories, checked against an ISA-level model.
// Rev 1.0
module tb_jimmy_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_a, reset_b;
  logic [7:0] prog [256];
  logic [7:0] dmem [256];
  logic [7:0] code_addr_a, code_addr_b, mem_addr_a, mem_addr_b;
  logic [7:0] code_data_a, code_data_b, mem_data_a, mem_data_b;
  logic [7:0] out2_a, out2_b;
  logic [3:0] strobe_a, strobe_b;
  logic [7:0] in0_a, in3_a, in0_b, in3_b;

  assign code_data_a = prog[code_addr_a];
  assign code_data_b = prog[code_addr_b];
  assign mem_data_a  = dmem[mem_addr_a];
  assign mem_data_b  = dmem[mem_addr_b];

  jimmy_core u_core_a (
    .clk(clk), .reset(reset_a),
    .code_data_bus(code_data_a), .code_addr_bus(code_addr_a),
    .mem_data_bus(mem_data_a), .mem_addr_bus(mem_addr_a),
    .in_port_0(in0_a), .in_port_3(in3_a),
    .out_port_2(out2_a), .out_strobe(strobe_a)
  );

  jimmy_core u_core_b (
    .clk(clk), .reset(reset_b),
    .code_data_bus(code_data_b), .code_addr_bus(code_addr_b),
    .mem_data_bus(mem_data_b), .mem_addr_bus(mem_addr_b),
    .in_port_0(in0_b), .in_port_3(in3_b),
    .out_port_2(out2_b), .out_strobe(strobe_b)
  );

  typedef struct {
    int         cyc;
    logic [3:0] mask;
    logic [7:0] val;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        obs_q[$];
  int         exp_total;
  logic [7:0] exp_halt_addr, exp_mem_addr, exp_port2;
  int         tests = 0;
  int         fails = 0;
  int         cyc_a;
  int         cnt_b;
  logic [7:0] val_b;

  // Cycles since reset release: the first rising edge after release is cycle 1.
  always @(posedge clk or negedge reset_a)
    if (!reset_a) cyc_a <= 0;
    else          cyc_a <= cyc_a + 1;

  always @(negedge clk) begin : mon_a
    ev_t e;
    if (reset_a && strobe_a != 4'b0000) begin
      e.cyc  = cyc_a;
      e.mask = strobe_a;
      e.val  = out2_a;
      obs_q.push_back(e);
    end
  end

  always @(negedge clk)
    if (!reset_b) cnt_b <= 0;
    else if (strobe_b[2]) begin
      cnt_b <= cnt_b + 1;
      val_b <= out2_b;
    end

  // Instruction-level interpreter: produces OUT events with their cycle stamps.
  task automatic model_run(input logic [7:0] in0, input logic [7:0] in3);
    logic [7:0] pc, at, pn, ir, imm, a, b;
    logic [7:0] r [4];
    logic [8:0] w;
    logic [1:0] d, s;
    logic       z, c, done;
    int         t;
    ev_t        e;
    pc = 8'd0; z = 1'b0; c = 1'b0; t = 0; done = 1'b0;
    for (int i = 0; i < 4; i++) r[i] = 8'd0;
    exp_q.delete();
    exp_mem_addr = 8'd0; exp_port2 = 8'd0; exp_halt_addr = 8'd0; exp_total = 0;
    for (int n = 0; n < 5000 && !done; n++) begin
      at = pc; pn = pc + 8'd1;
      ir = prog[at]; imm = prog[pn];
      d = ir[3:2]; s = ir[1:0]; a = r[d]; b = r[s];
      if (ir[7:4] == 4'h1 || (ir[7:4] >= 4'h8 && ir[7:4] <= 4'hB)) begin
        pc = pc + 8'd2; t += 5;
      end else begin
        pc = pc + 8'd1; t += (ir[7:4] == 4'h5) ? 5 : 3;
      end
      case (ir[7:4])
        4'h1: r[d] = imm;
        4'h2: r[d] = b;
        4'h3: begin w = a + b; r[d] = w[7:0]; c = w[8]; z = (w[7:0] == 8'd0); end
        4'h4: begin c = (b > a); r[d] = a - b; z = (r[d] == 8'd0); end
        4'h5: begin r[d] = dmem[b]; exp_mem_addr = b; end
        4'h6: r[d] = (s == 2'd0) ? in0 : ((s == 2'd3) ? in3 : 8'd0);
        4'h7: begin
          if (d == 2'd2) exp_port2 = b;
          e.cyc = t; e.mask = 4'b0001 << d; e.val = exp_port2;
          exp_q.push_back(e);
        end
        4'h8: pc = imm;
        4'h9: if (z)  pc = imm;
        4'hA: if (!z) pc = imm;
        4'hB: if (c)  pc = imm;
        4'hC: begin r[d] = a + 8'd1; z = (r[d] == 8'd0); c = z; end
        4'hD: begin c = (b > a); z = (a == b); end
        4'hE: begin exp_halt_addr = at; exp_total = t; done = 1'b1; end
        default: ;
      endcase
    end
  endtask

  task automatic run_a(input logic [7:0] in0, input logic [7:0] in3, input bit with_b);
    model_run(in0, in3);
    in0_a = in0; in3_a = in3;
    reset_a = 1'b0;
    reset_b = 1'b0;
    @(negedge clk);
    obs_q.delete();
    reset_a = 1'b1;
    if (with_b) reset_b = 1'b1;
    repeat (exp_total + 8) @(negedge clk);
  endtask

  task automatic load_range_sum();
    for (int i = 0; i < 256; i++) prog[i] = 8'hE0;
    prog[0]  = 8'h60; prog[1]  = 8'h67; prog[2]  = 8'h18; prog[3]  = 8'h00;
    prog[4]  = 8'h5C; prog[5]  = 8'h3B; prog[6]  = 8'hD1; prog[7]  = 8'h90;
    prog[8]  = 8'h0C; prog[9]  = 8'hC0; prog[10] = 8'h80; prog[11] = 8'h04;
    prog[12] = 8'h7A; prog[13] = 8'hE0;
  endtask

  task automatic test_reset();
    reset_a = 1'b0; reset_b = 1'b0;
    in0_a = 8'h5A; in3_a = 8'hA5; in0_b = 8'h33; in3_b = 8'hCC;
    for (int i = 0; i < 256; i++) begin prog[i] = 8'h00; dmem[i] = 8'(i); end
    repeat (5) @(negedge clk);
    tests++;
    if ({code_addr_a, mem_addr_a, out2_a, strobe_a} !== 28'd0) begin
      fails++;
      $display("FAIL reset_a outputs: got %h/%h/%h/%b required all zero", code_addr_a, mem_addr_a, out2_a, strobe_a);
    end
    tests++;
    if ({code_addr_b, mem_addr_b, out2_b, strobe_b} !== 28'd0) begin
      fails++;
      $display("FAIL reset_b outputs: got %h/%h/%h/%b required all zero", code_addr_b, mem_addr_b, out2_b, strobe_b);
    end
    reset_a = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      tests++;
      if (code_addr_a !== 8'((k - 1) / 3)) begin
        fails++;
        $display("FAIL nop_fetch cycle %0d: code_addr got %0d required %0d", k, code_addr_a, (k - 1) / 3);
      end
    end
  endtask

  task automatic test_add_out();
    for (int i = 0; i < 256; i++) prog[i] = 8'hE0;
    prog[0] = 8'h10; prog[1] = 8'd200; prog[2] = 8'h14; prog[3] = 8'd100;
    prog[4] = 8'h31; prog[5] = 8'h78;  prog[6] = 8'hB0; prog[7] = 8'h20;
    run_a(8'h00, 8'h00, 1'b0);
    tests++;
    if (obs_q.size() != 1) begin
      fails++; $display("FAIL add_out strobe count: got %0d required 1", obs_q.size());
    end else begin
      tests++;
      if (obs_q[0].val !== 8'd44 || obs_q[0].mask !== 4'b0100 || obs_q[0].cyc != 16) begin
        fails++;
        $display("FAIL add_out event: got val=%0d strobe=%b cyc=%0d required 44/0100/16", obs_q[0].val, obs_q[0].mask, obs_q[0].cyc);
      end
    end
    tests++;
    if (code_addr_a !== 8'h20 || out2_a !== 8'd44) begin
      fails++;
      $display("FAIL add_out carry/halt: got addr=%h port2=%0d required 20/44", code_addr_a, out2_a);
    end
  endtask

  task automatic test_sub_jz();
    logic [7:0] r1v;
    for (int k = 0; k < 2; k++) begin
      r1v = (k == 0) ? 8'd5 : 8'd6;
      for (int i = 0; i < 256; i++) prog[i] = 8'hE0;
      prog[0] = 8'h10; prog[1] = 8'd5;  prog[2] = 8'h14; prog[3] = r1v;
      prog[4] = 8'h41; prog[5] = 8'h90; prog[6] = 8'h40; prog[7] = 8'h78;
      prog[8] = 8'hB0; prog[9] = 8'h50; prog[8'h40] = 8'h78;
      run_a(8'h00, 8'h00, 1'b0);
      tests++;
      if (k == 0 && (code_addr_a !== 8'h41 || out2_a !== 8'h00 || obs_q.size() != 1)) begin
        fails++;
        $display("FAIL sub_jz taken: got addr=%h port2=%h outs=%0d required 41/00/1", code_addr_a, out2_a, obs_q.size());
      end
      if (k == 1 && (code_addr_a !== 8'h50 || out2_a !== 8'hFF || obs_q.size() != 1)) begin
        fails++;
        $display("FAIL sub_jz borrow: got addr=%h port2=%h outs=%0d required 50/ff/1", code_addr_a, out2_a, obs_q.size());
      end
    end
  endtask

  task automatic test_ld();
    for (int i = 0; i < 256; i++) begin prog[i] = 8'hE0; dmem[i] = 8'(i); end
    prog[0] = 8'h1C; prog[1] = 8'h7F; prog[2] = 8'h5B; prog[3] = 8'h7A;
    run_a(8'h00, 8'h00, 1'b0);
    tests++;
    if (mem_addr_a !== 8'h7F || out2_a !== 8'h7F || code_addr_a !== 8'h04) begin
      fails++;
      $display("FAIL ld result: got maddr=%h port2=%h addr=%h required 7f/7f/04", mem_addr_a, out2_a, code_addr_a);
    end
    tests++;
    if (obs_q.size() != 1 || obs_q[0].cyc != 13) begin
      fails++;
      $display("FAIL ld timing: got %0d events, first cyc=%0d required 1 event at 13", obs_q.size(), (obs_q.size() > 0) ? obs_q[0].cyc : -1);
    end
  endtask

  task automatic test_random();
    logic [3:0] ops [24];
    logic [7:0] st [25];
    logic [7:0] addr, nx;
    int         n;
    for (int it = 0; it < 25; it++) begin
      n = $urandom_range(6, 20);
      for (int i = 0; i < 256; i++) begin prog[i] = 8'hE0; dmem[i] = 8'($urandom); end
      addr = 8'd0;
      for (int i = 0; i < n; i++) begin
        ops[i] = 4'($urandom_range(0, 15));
        if (ops[i] == 4'hE) ops[i] = 4'h7;
        st[i] = addr;
        addr = addr + ((ops[i] == 4'h1 || ops[i] >= 4'h8 && ops[i] <= 4'hB) ? 8'd2 : 8'd1);
      end
      st[n] = addr;
      for (int i = 0; i < n; i++) begin
        prog[st[i]] = {ops[i], 4'($urandom)};
        nx = st[i] + 8'd1;
        if (ops[i] == 4'h1) prog[nx] = 8'($urandom);
        else if (ops[i] >= 4'h8 && ops[i] <= 4'hB) prog[nx] = st[$urandom_range(i + 1, n)];
      end
      run_a(8'($urandom), 8'($urandom), 1'b0);
      tests++;
      if (obs_q.size() != exp_q.size()) begin
        fails++;
        $display("FAIL random[%0d] out count: got %0d required %0d", it, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        tests++;
        if (obs_q[i].cyc != exp_q[i].cyc || obs_q[i].mask !== exp_q[i].mask || obs_q[i].val !== exp_q[i].val) begin
          fails++;
          $display("FAIL random[%0d] out %0d: got cyc=%0d strobe=%b port2=%h required cyc=%0d strobe=%b port2=%h",
                   it, i, obs_q[i].cyc, obs_q[i].mask, obs_q[i].val, exp_q[i].cyc, exp_q[i].mask, exp_q[i].val);
        end
      end
      tests++;
      if (code_addr_a !== exp_halt_addr || mem_addr_a !== exp_mem_addr || out2_a !== exp_port2) begin
        fails++;
        $display("FAIL random[%0d] final: got addr=%h maddr=%h port2=%h required %h/%h/%h",
                 it, code_addr_a, mem_addr_a, out2_a, exp_halt_addr, exp_mem_addr, exp_port2);
      end
    end
  endtask

  task automatic test_range_sum();
    logic [7:0] lo;
    load_range_sum();
    for (int i = 0; i < 256; i++) dmem[i] = 8'(i);
    in0_b = 8'd128; in3_b = 8'd255;
    run_a(8'd0, 8'd127, 1'b1);
    tests++;
    if (obs_q.size() != 1 || obs_q[0].val !== 8'd192 || obs_q[0].mask !== 4'b0100 || obs_q[0].cyc != exp_q[0].cyc) begin
      fails++;
      $display("FAIL range_a: got %0d pulses, port2=%0d required 1 pulse of 192 at cyc %0d", obs_q.size(), out2_a, exp_q[0].cyc);
    end
    tests++;
    if (cnt_b != 1 || val_b !== 8'd192 || out2_b !== 8'd192 || code_addr_b !== 8'h0D) begin
      fails++;
      $display("FAIL range_b: got %0d pulses, port2=%0d addr=%h required 1/192/0d", cnt_b, out2_b, code_addr_b);
    end
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 256; i++) dmem[i] = 8'($urandom);
      lo = 8'($urandom_range(0, 200));
      run_a(lo, lo + 8'($urandom_range(0, 40)), 1'b0);
      tests++;
      if (obs_q.size() != 1 || obs_q[0].val !== exp_q[0].val || obs_q[0].cyc != exp_q[0].cyc) begin
        fails++;
        $display("FAIL range_rand[%0d]: got %0d pulses, port2=%h required 1 pulse of %h", k, obs_q.size(), out2_a, exp_q[0].val);
      end
    end
  endtask

  task automatic test_reset_mid();
    int i;
    load_range_sum();
    for (int j = 0; j < 256; j++) dmem[j] = 8'(j);
    model_run(8'd0, 8'd127);
    in0_a = 8'd0; in3_a = 8'd127;
    for (int phase = 0; phase < 2; phase++) begin
      reset_a = 1'b0;
      @(negedge clk);
      reset_a = 1'b1;
      i = 0;
      while (i < 4000 && !((phase == 0) ? (mem_addr_a == 8'd5) : strobe_a[2])) begin
        @(negedge clk); i++;
      end
      tests++;
      if (i >= 4000) begin
        fails++; $display("FAIL reset_mid[%0d] trigger: got timeout required trigger", phase);
      end
      #2 reset_a = 1'b0;
      #1;
      tests++;
      if ({code_addr_a, mem_addr_a, out2_a, strobe_a} !== 28'd0) begin
        fails++;
        $display("FAIL reset_mid[%0d] async clear: got %h/%h/%h/%b required all zero", phase, code_addr_a, mem_addr_a, out2_a, strobe_a);
      end
      @(negedge clk);
      obs_q.delete();
      reset_a = 1'b1;
      repeat (exp_total + 8) @(negedge clk);
      tests++;
      if (obs_q.size() != 1 || obs_q[0].val !== 8'd192 || obs_q[0].cyc != exp_q[0].cyc || code_addr_a !== 8'h0D) begin
        fails++;
        $display("FAIL reset_mid[%0d] rerun: got %0d pulses port2=%0d addr=%h required 1/192/0d", phase, obs_q.size(), out2_a, code_addr_a);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_a = 1'b0;
    reset_b = 1'b0;
    test_reset();
    test_add_out();
    test_sub_jz();
    test_ld();
    test_random();
    test_range_sum();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
